// File: rtl/eeg_aram_rd_agu_if.sv
`default_nettype none
// ============================================================================
//  Module      : eeg_aram_rd_agu_if
//  Description : Bus bundle for the ARAM read-side AGU. It carries the window
//                configuration, the ARAM read-address and read-data channels,
//                and the output channel to the PE.
//  Revision    : 1.0  initial release
// ============================================================================
interface eeg_aram_rd_agu_if #(
  parameter int ADD_AW = 12,
  parameter int DAT_DW = 8,
  parameter int CNT_DW = 8
) ();

  // Configuration channel
  logic              CFG_INFO_VLD;
  logic              CFG_INFO_RDY;
  logic [ADD_AW-1:0] CFG_BASE_ADD;
  logic [CNT_DW-1:0] CFG_ROW_NUM;
  logic [CNT_DW-1:0] CFG_COL_NUM;
  logic [ADD_AW-1:0] CFG_ROW_STR;

  // ARAM read-address channel
  logic              ARAM_ADD_VLD;
  logic              ARAM_ADD_LST;
  logic              ARAM_ADD_RDY;
  logic [ADD_AW-1:0] ARAM_ADD_ADD;

  // ARAM read-data channel
  logic              ARAM_DAT_VLD;
  logic              ARAM_DAT_LST;
  logic              ARAM_DAT_RDY;
  logic [DAT_DW-1:0] ARAM_DAT_DAT;

  // Output channel to the PE
  logic              OUT_DAT_VLD;
  logic              OUT_DAT_LST;
  logic              OUT_DAT_RDY;
  logic [DAT_DW-1:0] OUT_DAT_DAT;

  // AGU side of the bundle
  modport master (
    input  CFG_INFO_VLD, CFG_BASE_ADD, CFG_ROW_NUM, CFG_COL_NUM, CFG_ROW_STR,
    output CFG_INFO_RDY,
    output ARAM_ADD_VLD, ARAM_ADD_LST, ARAM_ADD_ADD,
    input  ARAM_ADD_RDY,
    input  ARAM_DAT_VLD, ARAM_DAT_LST, ARAM_DAT_DAT,
    output ARAM_DAT_RDY,
    output OUT_DAT_VLD, OUT_DAT_LST, OUT_DAT_DAT,
    input  OUT_DAT_RDY
  );

  // Environment side: configuration source, ARAM and PE
  modport slave (
    output CFG_INFO_VLD, CFG_BASE_ADD, CFG_ROW_NUM, CFG_COL_NUM, CFG_ROW_STR,
    input  CFG_INFO_RDY,
    input  ARAM_ADD_VLD, ARAM_ADD_LST, ARAM_ADD_ADD,
    output ARAM_ADD_RDY,
    output ARAM_DAT_VLD, ARAM_DAT_LST, ARAM_DAT_DAT,
    input  ARAM_DAT_RDY,
    input  OUT_DAT_VLD, OUT_DAT_LST, OUT_DAT_DAT,
    output OUT_DAT_RDY
  );

endinterface
`default_nettype wire

// File: rtl/eeg_aram_rd_agu.sv
`default_nettype none
// ============================================================================
//  Module      : eeg_aram_rd_agu
//  Description : Read-side address generator for one ARAM bank. It walks a
//                2-D window in row-major order, credit-limits the outstanding
//                reads to the output FIFO depth, and buffers the returned
//                data in a FWFT FIFO for the PE.
//  Revision    : 1.0  initial release
// ============================================================================
module eeg_aram_rd_agu #(
  parameter int ADD_AW     = 12,
  parameter int DAT_DW     = 8,
  parameter int CNT_DW     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  wire logic          clk,
  input  wire logic          rst,
  eeg_aram_rd_agu_if.master  bus,
  output logic               IS_IDLE,
  output logic               ERR_OVF
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CRD_W = PTR_W + 1;
  localparam int ENT_W = DAT_DW + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t            state;
  logic [ADD_AW-1:0] row_str;
  logic [ADD_AW-1:0] row_base;
  logic [CNT_DW-1:0] row_num;
  logic [CNT_DW-1:0] col_num;
  logic [CNT_DW-1:0] row_cnt;
  logic [CNT_DW-1:0] col_cnt;
  logic [CRD_W-1:0]  credit;

  logic [ENT_W-1:0]  fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CRD_W-1:0]  fifo_cnt;
  logic              ovf_flag;

  logic              cfg_hs;
  logic              add_vld;
  logic              add_lst;
  logic              add_hs;
  logic              col_end;
  logic              row_end;
  logic              push;
  logic              wr_en;
  logic              ovf_evt;
  logic              fifo_full;
  logic              out_vld;
  logic              out_lst;
  logic              pop;
  logic [ENT_W-1:0]  head;

  // Handshakes and address-walk decode
  assign cfg_hs   = bus.CFG_INFO_VLD && (state == ST_IDLE);
  assign add_vld  = (state == ST_RUN) && (credit < CRD_W'(FIFO_DEPTH));
  assign col_end  = (col_cnt == col_num);
  assign row_end  = (row_cnt == row_num);
  assign add_lst  = (state == ST_RUN) && col_end && row_end;
  assign add_hs   = add_vld && bus.ARAM_ADD_RDY;

  // FIFO decode; a push into a full FIFO is only kept if a pop frees a slot
  assign fifo_full = (fifo_cnt == CRD_W'(FIFO_DEPTH));
  assign out_vld   = (fifo_cnt != '0);
  assign head      = fifo_mem[rd_ptr];
  assign out_lst   = out_vld && head[DAT_DW];
  assign pop       = out_vld && bus.OUT_DAT_RDY;
  assign push      = bus.ARAM_DAT_VLD && bus.ARAM_DAT_RDY;
  assign wr_en     = push && (!fifo_full || pop);
  assign ovf_evt   = push && fifo_full && !pop;

  // Output drive
  assign bus.CFG_INFO_RDY = (state == ST_IDLE);
  assign bus.ARAM_ADD_VLD = add_vld;
  assign bus.ARAM_ADD_LST = add_lst;
  assign bus.ARAM_ADD_ADD = row_base + ADD_AW'(col_cnt);
  assign bus.ARAM_DAT_RDY = !rst;
  assign bus.OUT_DAT_VLD  = out_vld;
  assign bus.OUT_DAT_LST  = out_lst;
  assign bus.OUT_DAT_DAT  = out_vld ? head[DAT_DW-1:0] : '0;
  assign IS_IDLE          = (state == ST_IDLE);
  assign ERR_OVF          = ovf_flag;

  // Window FSM, address counters and read credit
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      row_str  <= '0;
      row_base <= '0;
      row_num  <= '0;
      col_num  <= '0;
      row_cnt  <= '0;
      col_cnt  <= '0;
      credit   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cfg_hs) begin
            row_base <= bus.CFG_BASE_ADD;
            row_str  <= bus.CFG_ROW_STR;
            row_num  <= bus.CFG_ROW_NUM;
            col_num  <= bus.CFG_COL_NUM;
            row_cnt  <= '0;
            col_cnt  <= '0;
            state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (add_hs) begin
            if (col_end) begin
              col_cnt  <= '0;
              row_cnt  <= row_cnt + 1'b1;
              row_base <= row_base + row_str;
            end else begin
              col_cnt  <= col_cnt + 1'b1;
            end
            if (add_lst) begin
              state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (pop && out_lst) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      // Credit tracks reads issued but not yet consumed by the PE
      if (add_hs && !pop) begin
        credit <= credit + 1'b1;
      end else if (!add_hs && pop && (credit != '0)) begin
        credit <= credit - 1'b1;
      end
    end
  end

  // FIFO storage; contents need no reset because the head is masked when empty
  always_ff @(posedge clk) begin
    if (wr_en) begin
      fifo_mem[wr_ptr] <= {bus.ARAM_DAT_LST, bus.ARAM_DAT_DAT};
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      ovf_flag <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (wr_en && !pop) begin
        fifo_cnt <= fifo_cnt + 1'b1;
      end else if (!wr_en && pop) begin
        fifo_cnt <= fifo_cnt - 1'b1;
      end
      // An overflow in the same cycle as a new config still gets reported
      if (ovf_evt) begin
        ovf_flag <= 1'b1;
      end else if (cfg_hs) begin
        ovf_flag <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_eeg_aram_rd_agu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_eeg_aram_rd_agu
//  Description : Self-checking bench for eeg_aram_rd_agu with an in-order ARAM
//                model of random latency and a window-level reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_eeg_aram_rd_agu;

  localparam int ADD_AW     = 12;
  localparam int DAT_DW     = 8;
  localparam int CNT_DW     = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int BOUND      = 3000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic is_idle;
  logic err_ovf;

  always #5 clk = ~clk;

  eeg_aram_rd_agu_if #(.ADD_AW(ADD_AW), .DAT_DW(DAT_DW), .CNT_DW(CNT_DW)) ifc ();

  eeg_aram_rd_agu #(
    .ADD_AW(ADD_AW), .DAT_DW(DAT_DW), .CNT_DW(CNT_DW), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .bus(ifc), .IS_IDLE(is_idle), .ERR_OVF(err_ovf)
  );

  typedef struct { int due; logic lst; logic [7:0] dat; } ret_t;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          add_mode = 0;   // 0: ready, 1: random, 2: stalled
  int          out_mode = 0;   // 0: ready, 1: random, 2: stalled, 3: ready
  bit          poke_en  = 0;
  int          n_addr   = 0;
  int          n_out    = 0;
  int          outstanding = 0;
  logic [7:0]  mem_img [4096];
  logic [12:0] exp_addr [$];   // {lst, address}
  logic [8:0]  exp_out  [$];   // {lst, data}
  ret_t        pipe     [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected stream from the window definition: address = base + r*stride + c
  task automatic load_model(input logic [11:0] base, input int rn, input int cn,
                            input logic [11:0] str);
    logic [11:0] a;
    logic        l;
    exp_addr.delete();
    exp_out.delete();
    for (int r = 0; r <= rn; r++) begin
      for (int c = 0; c <= cn; c++) begin
        a = 12'(int'(base) + r * int'(str) + c);
        l = (r == rn) && (c == cn);
        exp_addr.push_back({l, a});
        exp_out.push_back({l, mem_img[a]});
      end
    end
  endtask

  task automatic drive_cfg(input logic [11:0] base, input int rn, input int cn,
                           input logic [11:0] str);
    ifc.CFG_INFO_VLD = 1'b1;
    ifc.CFG_BASE_ADD = base;
    ifc.CFG_ROW_NUM  = 8'(rn);
    ifc.CFG_COL_NUM  = 8'(cn);
    ifc.CFG_ROW_STR  = str;
  endtask

  // One clock: drive at negedge, check handshakes, advance to next negedge
  task automatic cycle();
    logic [12:0] ea;
    logic [8:0]  eo;
    ret_t        r;
    bit          last_pop;
    bit          add_hs;
    last_pop = 0;
    ifc.ARAM_ADD_RDY = (add_mode == 0) ? 1'b1 :
                       (add_mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b0;
    ifc.OUT_DAT_RDY  = (out_mode == 0 || out_mode == 3) ? 1'b1 :
                       (out_mode == 1) ? ($urandom_range(0, 2) != 0) : 1'b0;
    if (pipe.size() > 0 && pipe[0].due <= cyc) begin
      r = pipe.pop_front();
      ifc.ARAM_DAT_VLD = 1'b1;
      ifc.ARAM_DAT_DAT = r.dat;
      ifc.ARAM_DAT_LST = r.lst;
    end else begin
      ifc.ARAM_DAT_VLD = 1'b0;
      ifc.ARAM_DAT_DAT = 8'($urandom);
      ifc.ARAM_DAT_LST = 1'($urandom);
    end
    if (poke_en) begin
      ifc.CFG_INFO_VLD = !is_idle;
      if (!is_idle) begin
        ifc.CFG_BASE_ADD = 12'($urandom);
        ifc.CFG_ROW_NUM  = 8'($urandom);
        ifc.CFG_COL_NUM  = 8'($urandom);
        ifc.CFG_ROW_STR  = 12'($urandom);
      end
    end
    #1;
    if (poke_en && !is_idle) chk("cfg_rdy_busy", ifc.CFG_INFO_RDY, 0);
    add_hs = ifc.ARAM_ADD_VLD && ifc.ARAM_ADD_RDY;
    if (add_hs) begin
      n_addr++;
      outstanding++;
      total++;
      assert (exp_addr.size() != 0) else begin
        bad++;
        $error("FAIL extra_addr observed=%0h expected=none", ifc.ARAM_ADD_ADD);
      end
      if (exp_addr.size() != 0) begin
        ea = exp_addr.pop_front();
        chk("aram_add", ifc.ARAM_ADD_ADD, ea[11:0]);
        chk("aram_lst", ifc.ARAM_ADD_LST, ea[12]);
      end
      pipe.push_back('{due: cyc + 1 + int'($urandom_range(0, 2)),
                       lst: ifc.ARAM_ADD_LST, dat: mem_img[ifc.ARAM_ADD_ADD]});
    end
    if (ifc.OUT_DAT_VLD && ifc.OUT_DAT_RDY) begin
      n_out++;
      outstanding--;
      total++;
      assert (exp_out.size() != 0) else begin
        bad++;
        $error("FAIL extra_out observed=%0h expected=none", ifc.OUT_DAT_DAT);
      end
      if (exp_out.size() != 0) begin
        eo = exp_out.pop_front();
        chk("out_dat", ifc.OUT_DAT_DAT, eo[7:0]);
        chk("out_lst", ifc.OUT_DAT_LST, eo[8]);
      end
      last_pop = ifc.OUT_DAT_LST;
    end
    if (add_hs) chk("credit_limit", (outstanding <= FIFO_DEPTH), 1);
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (last_pop) chk("idle_after_last", is_idle, 1);
  endtask

  task automatic finish_window();
    int k;
    k = 0;
    while (!(exp_out.size() == 0 && is_idle) && k < BOUND) begin
      cycle();
      k++;
    end
    ifc.CFG_INFO_VLD = 1'b0;
    chk("window_done", (k < BOUND), 1);
    chk("addr_left", exp_addr.size(), 0);
    chk("ovf_clear", err_ovf, 0);
  endtask

  task automatic run_window(input logic [11:0] base, input int rn, input int cn,
                            input logic [11:0] str);
    bit save_poke;
    n_addr = 0;
    n_out  = 0;
    load_model(base, rn, cn, str);
    chk("cfg_rdy_idle", ifc.CFG_INFO_RDY, 1);
    save_poke = poke_en;
    poke_en   = 0;
    drive_cfg(base, rn, cn, str);
    cycle();
    ifc.CFG_INFO_VLD = 1'b0;
    poke_en = save_poke;
    chk("first_vld", ifc.ARAM_ADD_VLD, 1);
    finish_window();
    chk("n_addr", n_addr, (rn + 1) * (cn + 1));
    chk("n_out", n_out, (rn + 1) * (cn + 1));
  endtask

  task automatic chk_reset_outs(input logic dat_rdy);
    chk("rst_idle", is_idle, 1);
    chk("rst_cfg_rdy", ifc.CFG_INFO_RDY, 1);
    chk("rst_add_vld", ifc.ARAM_ADD_VLD, 0);
    chk("rst_add_lst", ifc.ARAM_ADD_LST, 0);
    chk("rst_add_add", ifc.ARAM_ADD_ADD, 0);
    chk("rst_dat_rdy", ifc.ARAM_DAT_RDY, dat_rdy);
    chk("rst_out_vld", ifc.OUT_DAT_VLD, 0);
    chk("rst_out_lst", ifc.OUT_DAT_LST, 0);
    chk("rst_out_dat", ifc.OUT_DAT_DAT, 0);
    chk("rst_ovf", err_ovf, 0);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem_img[i] = 8'($urandom);
    ifc.CFG_INFO_VLD = 1'b0;
    ifc.CFG_BASE_ADD = '0;
    ifc.CFG_ROW_NUM  = '0;
    ifc.CFG_COL_NUM  = '0;
    ifc.CFG_ROW_STR  = '0;
    ifc.ARAM_ADD_RDY = 1'b0;
    ifc.ARAM_DAT_VLD = 1'b0;
    ifc.ARAM_DAT_LST = 1'b0;
    ifc.ARAM_DAT_DAT = '0;
    ifc.OUT_DAT_RDY  = 1'b0;

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_outs(1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("dat_rdy_run", ifc.ARAM_DAT_RDY, 1);

    // Basic window, address wrap, single element
    add_mode = 0; out_mode = 0;
    run_window(12'h010, 1, 2, 12'h020);
    run_window(12'hFFE, 1, 3, 12'h004);
    run_window(12'h123, 0, 0, 12'h000);

    // Back-pressure from the PE
    add_mode = 0; out_mode = 2;
    n_addr = 0; n_out = 0;
    load_model(12'h010, 1, 2, 12'h020);
    drive_cfg(12'h010, 1, 2, 12'h020);
    cycle();
    ifc.CFG_INFO_VLD = 1'b0;
    repeat (10) cycle();
    chk("bp_out_dat_a", ifc.OUT_DAT_DAT, mem_img[12'h010]);
    repeat (10) cycle();
    chk("bp_addr_cnt", n_addr, 4);
    chk("bp_add_vld", ifc.ARAM_ADD_VLD, 0);
    chk("bp_out_vld", ifc.OUT_DAT_VLD, 1);
    chk("bp_out_dat_b", ifc.OUT_DAT_DAT, mem_img[12'h010]);
    chk("bp_out_lst", ifc.OUT_DAT_LST, 0);
    out_mode = 3;
    cycle();
    out_mode = 2;
    repeat (10) cycle();
    chk("bp_addr_cnt2", n_addr, 5);
    chk("bp_out_cnt", n_out, 1);
    chk("bp_out_dat_c", ifc.OUT_DAT_DAT, mem_img[12'h011]);
    chk("bp_ovf", err_ovf, 0);
    out_mode = 0;
    finish_window();
    chk("bp_n_out", n_out, 6);

    // Config pulses while busy must be ignored
    poke_en = 1; add_mode = 1; out_mode = 1;
    run_window(12'h200, 2, 3, 12'h010);
    poke_en = 0;
    cycle();
    chk("idle_hold", is_idle, 1);
    run_window(12'h3A0, 1, 1, 12'h100);

    // Reset in the middle of a window
    add_mode = 0; out_mode = 2;
    n_addr = 0; n_out = 0;
    load_model(12'h010, 1, 2, 12'h020);
    drive_cfg(12'h010, 1, 2, 12'h020);
    cycle();
    ifc.CFG_INFO_VLD = 1'b0;
    repeat (3) cycle();
    add_mode = 2;
    repeat (5) cycle();
    chk("mr_addr_cnt", n_addr, 3);
    chk("mr_buffered", ifc.OUT_DAT_VLD, 1);
    rst = 1'b1;
    ifc.ARAM_DAT_VLD = 1'b0;
    pipe.delete();
    exp_addr.delete();
    exp_out.delete();
    outstanding = 0;
    @(negedge clk);
    chk_reset_outs(1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("mr_fifo_empty", ifc.OUT_DAT_VLD, 0);
    add_mode = 1; out_mode = 1;
    run_window(12'h010, 1, 2, 12'h020);

    // Random windows under random handshakes
    for (int t = 0; t < 6; t++) begin
      add_mode = int'($urandom_range(0, 1));
      out_mode = int'($urandom_range(0, 1));
      run_window(12'($urandom), int'($urandom_range(0, 4)), int'($urandom_range(0, 5)),
                 12'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
